// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: FSM sequencing the multi-cycle RV32I datapath and driving its control inputs
module multicycle_control_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instrCode,
  output logic        PCEn,
  output logic        regFileWe,
  output logic [3:0]  aluControl,
  output logic        aluSrcMuxSel,
  output logic [2:0]  RFWDSrcMuxSel,
  output logic        branch,
  output logic        jal,
  output logic        jalr,
  output logic        busWe,
  output logic        illegalInstr
);
  typedef enum logic [3:0] {
    FETCH, DECODE, R_EXE, I_EXE, B_EXE, LU_EXE, AU_EXE,
    J_EXE, JL_EXE, S_EXE, S_MEM, L_EXE, L_MEM, L_WB
  } state_t;
  localparam state_t RESET_STATE = FETCH;
  state_t state, state_next;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic unused_bits;
  assign opcode = instrCode[6:0];
  assign funct3 = instrCode[14:12];
  assign unused_bits = ^{instrCode[31], instrCode[29:15], instrCode[11:7]};
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= RESET_STATE;
    else state <= state_next;
  always_comb begin
    state_next = FETCH;
    case (state)
      FETCH: state_next = DECODE;
      DECODE:
        case (opcode)
          7'b0110011: state_next = R_EXE;
          7'b0010011: state_next = I_EXE;
          7'b1100011: state_next = B_EXE;
          7'b0110111: state_next = LU_EXE;
          7'b0010111: state_next = AU_EXE;
          7'b1101111: state_next = J_EXE;
          7'b1100111: state_next = JL_EXE;
          7'b0100011: state_next = S_EXE;
          7'b0000011: state_next = L_EXE;
          default:    state_next = FETCH;
        endcase
      S_EXE: state_next = S_MEM;
      L_EXE: state_next = L_MEM;
      L_MEM: state_next = L_WB;
      default: state_next = FETCH;
    endcase
  end
  always_comb begin
    PCEn = 1'b0;
    regFileWe = 1'b0;
    aluControl = 4'b0000;
    aluSrcMuxSel = 1'b0;
    RFWDSrcMuxSel = 3'd0;
    branch = 1'b0;
    jal = 1'b0;
    jalr = 1'b0;
    busWe = 1'b0;
    illegalInstr = 1'b0;
    case (state)
      FETCH: PCEn = 1'b1;
      DECODE: illegalInstr = (state_next == FETCH);
      R_EXE: begin
        regFileWe = 1'b1;
        aluControl = {instrCode[30], funct3};
      end
      I_EXE: begin
        regFileWe = 1'b1;
        aluSrcMuxSel = 1'b1;
        // only shifts use bit 30; immediates of other ops may set it freely
        aluControl = {(funct3 == 3'b101) ? instrCode[30] : 1'b0, funct3};
      end
      B_EXE: begin
        branch = 1'b1;
        aluControl = {1'b0, funct3};
      end
      LU_EXE: begin
        regFileWe = 1'b1;
        RFWDSrcMuxSel = 3'd2;
      end
      AU_EXE: begin
        regFileWe = 1'b1;
        RFWDSrcMuxSel = 3'd3;
      end
      J_EXE: begin
        jal = 1'b1;
        regFileWe = 1'b1;
        RFWDSrcMuxSel = 3'd4;
      end
      JL_EXE: begin
        jal = 1'b1;
        jalr = 1'b1;
        regFileWe = 1'b1;
        RFWDSrcMuxSel = 3'd4;
      end
      S_EXE, L_EXE, L_MEM: aluSrcMuxSel = 1'b1;
      S_MEM: begin
        aluSrcMuxSel = 1'b1;
        busWe = 1'b1;
      end
      L_WB: begin
        aluSrcMuxSel = 1'b1;
        regFileWe = 1'b1;
        RFWDSrcMuxSel = 3'd1;
      end
      default: PCEn = 1'b0;
    endcase
  end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: per-cycle scoreboard of expected control vectors for directed instructions
module tb_multicycle_control_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] instrCode = 32'h0;
  logic PCEn, regFileWe, aluSrcMuxSel, branch, jal, jalr, busWe, illegalInstr;
  logic [3:0] aluControl;
  logic [2:0] RFWDSrcMuxSel;
  logic [14:0] q[$];
  int checks = 0;
  int errors = 0;
  multicycle_control_unit dut (
    .clk(clk), .reset(reset), .instrCode(instrCode), .PCEn(PCEn), .regFileWe(regFileWe),
    .aluControl(aluControl), .aluSrcMuxSel(aluSrcMuxSel), .RFWDSrcMuxSel(RFWDSrcMuxSel),
    .branch(branch), .jal(jal), .jalr(jalr), .busWe(busWe), .illegalInstr(illegalInstr)
  );
  always #5 clk = ~clk;
  function automatic logic [14:0] row(input logic pc, we, input logic [3:0] alu, input logic src,
                                      input logic [2:0] wd, input logic br, j, jr, bw, ill);
    return {pc, we, alu, src, wd, br, j, jr, bw, ill};
  endfunction
  localparam logic [14:0] F   = 15'b1_0_0000_0_000_00000;
  localparam logic [14:0] D   = 15'b0_0_0000_0_000_00000;
  localparam logic [14:0] LSA = 15'b0_0_0000_1_000_00000;
  always @(negedge clk) begin
    logic [14:0] got, exp;
    if (q.size() > 0) begin
      exp = q.pop_front();
      got = {PCEn, regFileWe, aluControl, aluSrcMuxSel, RFWDSrcMuxSel, branch, jal, jalr, busWe, illegalInstr};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL cycle_vector instr=%h got=%b expected=%b", instrCode, got, exp);
      end
    end
  end
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [31:0] ins, input int n);
    instrCode = ins;
    cycles(n);
  endtask
  initial begin
    cycles(2);
    q.push_back(F);
    cycles(1);
    reset = 1'b0;
    q.push_back(F); q.push_back(D); q.push_back(row(0,1,4'b0000,0,0,0,0,0,0,0));
    issue(32'h002081B3, 3);
    q.push_back(F); q.push_back(D); q.push_back(row(0,1,4'b1000,0,0,0,0,0,0,0));
    issue(32'h402081B3, 3);
    q.push_back(F); q.push_back(D); q.push_back(row(0,1,4'b1101,1,0,0,0,0,0,0));
    issue(32'h4030D093, 3);
    q.push_back(F); q.push_back(D); q.push_back(row(0,1,4'b0000,1,0,0,0,0,0,0));
    issue(32'hC0000093, 3);
    q.push_back(F); q.push_back(D); q.push_back(LSA); q.push_back(LSA);
    q.push_back(row(0,1,4'b0000,1,1,0,0,0,0,0));
    issue(32'h00802283, 5);
    q.push_back(F); q.push_back(D); q.push_back(LSA); q.push_back(row(0,0,4'b0000,1,0,0,0,0,1,0));
    issue(32'h00502623, 4);
    q.push_back(F); q.push_back(D); q.push_back(row(0,0,4'b0000,0,0,1,0,0,0,0));
    issue(32'h00000463, 3);
    q.push_back(F); q.push_back(D); q.push_back(row(0,0,4'b0001,0,0,1,0,0,0,0));
    issue(32'h00101463, 3);
    q.push_back(F); q.push_back(D); q.push_back(row(0,1,4'b0000,0,4,0,1,1,0,0));
    issue(32'h000100E7, 3);
    q.push_back(F); q.push_back(D); q.push_back(row(0,1,4'b0000,0,4,0,1,0,0,0));
    issue(32'h008000EF, 3);
    q.push_back(F); q.push_back(D); q.push_back(row(0,1,4'b0000,0,2,0,0,0,0,0));
    issue(32'h123450B7, 3);
    q.push_back(F); q.push_back(D); q.push_back(row(0,1,4'b0000,0,3,0,0,0,0,0));
    issue(32'h00000097, 3);
    q.push_back(F); q.push_back(row(0,0,4'b0000,0,0,0,0,0,0,1));
    issue(32'h0000007F, 2);
    // reset lands in L_MEM: the load must restart from FETCH without writing back
    q.push_back(F); q.push_back(D); q.push_back(LSA);
    q.push_back(F); q.push_back(F); q.push_back(F);
    q.push_back(D); q.push_back(LSA); q.push_back(LSA);
    q.push_back(row(0,1,4'b0000,1,1,0,0,0,0,0));
    issue(32'h00802283, 3);
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    cycles(5);
    q.push_back(F);
    cycles(1);
    for (int i = 0; i < 20 && q.size() > 0; i++) cycles(1);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
